// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and sizing helpers for the FIFO write-side arbiter
// Contents: arbitration state enum, FIFO data width default, ID width helper.
package fifo_arb_pkg;
  typedef enum logic {ARB, LOCK} arb_state_t;
  localparam int FIFO_DATA_W = 5;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc: rotating-priority encoder, finds first set req bit at or above rr_ptr (mod REQ_N)
// Ports: req (request vector), rr_ptr (search start), found (any request), idx (winner index, 0 when none).
module rr_prio_enc #(
  parameter int REQ_N = 4,
  parameter int ID_W = 2
) (
  input  logic [REQ_N-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);
  always_comb begin
    int j;
    j = 0;
    found = |req;
    idx = '0;
    // Walk offsets from highest to lowest so the nearest request to rr_ptr is written last.
    for (int i = REQ_N - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i) % REQ_N;
      if (req[j[ID_W-1:0]]) idx = j[ID_W-1:0];
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among REQ_N valid/ready producers
// Ports: clk_i, a_rst_n_i (async active-low), req_valid_i/req_data_i/req_ready_o (producers),
//        fifo_wr_req_o/fifo_wr_data_o/fifo_full_i (FIFO side), grant_id_o (current winner).
// Option: define FIFO_ARB_BURST_EN to hold a grant for up to BURST_MAX consecutive beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int REQ_N = 4,
  parameter int DATA_W = FIFO_DATA_W,
  parameter int BURST_MAX = 4,
  localparam int ID_W = id_w(REQ_N)
) (
  input  logic                    clk_i,
  input  logic                    a_rst_n_i,
  input  logic [REQ_N-1:0]        req_valid_i,
  input  logic [REQ_N*DATA_W-1:0] req_data_i,
  output logic [REQ_N-1:0]        req_ready_o,
  output logic                    fifo_wr_req_o,
  output logic [DATA_W-1:0]       fifo_wr_data_o,
  input  logic                    fifo_full_i,
  output logic [ID_W-1:0]         grant_id_o
);
  logic [ID_W-1:0] rr_ptr, enc_idx, winner, nxt_ptr;
  logic enc_found, win_valid;
  rr_prio_enc #(.REQ_N(REQ_N), .ID_W(ID_W)) u_enc (
    .req(req_valid_i),
    .rr_ptr(rr_ptr),
    .found(enc_found),
    .idx(enc_idx)
  );
`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  arb_state_t state;
  logic [ID_W-1:0] lock_id;
  logic [CNT_W-1:0] burst_cnt;
  assign winner = (state == LOCK) ? lock_id : enc_idx;
  assign win_valid = (state == LOCK) ? req_valid_i[lock_id] : enc_found;
`else
  assign winner = enc_idx;
  assign win_valid = enc_found;
`endif
  // Full gates the strobe directly: the FIFO writes memory on wr_req even when full.
  assign fifo_wr_req_o = win_valid && !fifo_full_i;
  assign fifo_wr_data_o = win_valid ? req_data_i[winner*DATA_W +: DATA_W] : '0;
  assign grant_id_o = win_valid ? winner : '0;
  assign req_ready_o = fifo_wr_req_o ? (REQ_N'(1) << winner) : '0;
  assign nxt_ptr = (winner == ID_W'(REQ_N - 1)) ? '0 : winner + 1'b1;
`ifdef FIFO_ARB_BURST_EN
  // In LOCK the winner is lock_id, so nxt_ptr is lock_id+1 on both burst end and early drop.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state <= ARB;
      lock_id <= '0;
      burst_cnt <= '0;
      rr_ptr <= '0;
    end else if (!fifo_full_i) begin
      if (state == ARB) begin
        if (fifo_wr_req_o) begin
          if (BURST_MAX > 1) begin
            state <= LOCK;
            lock_id <= winner;
            burst_cnt <= CNT_W'(1);
          end else rr_ptr <= nxt_ptr;
        end
      end else if (fifo_wr_req_o && burst_cnt != CNT_W'(BURST_MAX - 1)) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        state <= ARB;
        rr_ptr <= nxt_ptr;
        burst_cnt <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) rr_ptr <= '0;
    else if (fifo_wr_req_o) rr_ptr <= nxt_ptr;
  end
`endif
  a_no_write_when_full: assert property (@(posedge clk_i) disable iff (!a_rst_n_i) !(fifo_wr_req_o && fifo_full_i));
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO write port (wr_req / wr_data / full) among REQ_N producers.
- Each producer has a valid/ready handshake. The winner's word is forwarded to the FIFO in the same cycle (zero-latency combinational path).
- Arbitration state is registered.
- Sits directly in front of the team FIFO.

Parameters:
- REQ_N, 4: number of requesters (2..16).
- DATA_W, 5: data width; matches the FIFO DATA_W.
- BURST_MAX, 4: maximum consecutive accepted beats per grant. Used only with the burst feature; >=1.
- Derived constant ID_W = $clog2(REQ_N).

Ports:
- clk_i  in  1  clock
- a_rst_n_i  in  1  reset
- req_valid_i  in  REQ_N  per-source word valid
- req_data_i  in  REQ_N*DATA_W  packed source data; source k occupies bits [k*DATA_W +: DATA_W]
- req_ready_o  out  REQ_N  per-source accept; at most one bit set
- fifo_wr_req_o  out  1  FIFO write strobe
- fifo_wr_data_o  out  DATA_W  FIFO write data
- fifo_full_i  in  1  FIFO full flag
- grant_id_o  out  ID_W  index of the current winner; valid when fifo_wr_req_o=1

Interface (already decided): one clock, clk_i; reset a_rst_n_i is asynchronous and active-low.

Behaviour:
- Reset (a_rst_n_i=0, asynchronous):
  - rr_ptr=0, state=ARB, burst_cnt=0.
  - All outputs are combinational from state and inputs. With req_valid_i=0 they read 0: req_ready_o=0, fifo_wr_req_o=0, grant_id_o=0, fifo_wr_data_o=0.
- Winner selection:
  - In ARB, the winner is the first set bit of req_valid_i, searching from rr_ptr upward modulo REQ_N.
  - In LOCK, the winner is lock_id.
- Write strobe:
  - fifo_wr_req_o = winner valid && !fifo_full_i.
  - The FIFO writes memory on wr_req even when full, so fifo_wr_req_o must never be 1 while fifo_full_i=1. This is a hard requirement and is asserted.
- Data and handshake:
  - fifo_wr_data_o = winner's data slice whenever a winner exists, otherwise 0.
  - req_ready_o[winner] = fifo_wr_req_o. A beat is accepted on a cycle with valid&&ready.
- Pointer update:
  - On accept without the burst feature, rr_ptr <= winner+1 (wrapping REQ_N-1 -> 0).
  - No accept: rr_ptr holds.
- Fairness: with all sources continuously valid and FIFO never full, grants cycle 0,1,...,REQ_N-1,0. Any valid source waits at most REQ_N-1 accepts.
- Stall: while fifo_full_i=1, nothing is accepted and no state changes. The winner index may still change combinationally as valids change.
- Sources may drop valid without being accepted; no stickiness is required in ARB.
- Single requester: granted every non-full cycle (back-to-back, 1 word/clk).
- Reset mid-transfer: state clears immediately. No FIFO write occurs in the reset cycle because the outputs depend on valid and !full only, and the producer is expected to be held in reset too.

Optional Feature:
- Macro FIFO_ARB_BURST_EN.
- Defined:
  - Two-state FSM: ARB and LOCK.
  - ARB, on accept from source k:
    - If BURST_MAX>1: go to LOCK, lock_id<=k, burst_cnt<=1.
    - If BURST_MAX=1: stay in ARB and rr_ptr<=k+1.
  - LOCK, on accept: burst_cnt++. When burst_cnt reaches BURST_MAX: go to ARB, rr_ptr<=lock_id+1, burst_cnt<=0.
  - LOCK, lock_id drops valid with no accept: go to ARB the same edge, rr_ptr<=lock_id+1. That cycle grants no one else.
  - LOCK while full: hold state and count.
- Undefined: the FSM is absent, arbitration is ARB-only, and BURST_MAX is ignored.

Decomposition:
- Package fifo_arb_pkg:
  - state enum arb_state_t {ARB, LOCK}
  - function for ID_W sizing
  - default DATA_W constant shared with the FIFO
- Sub-module rr_prio_enc (REQ_N): combinational rotate-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, idx.
  - Reusable by a future read-side scheduler.

Test Plan:
- Reset release, REQ_N=4, all valid, full=0, 8 cycles -> grant_id_o sequence 0,1,2,3,0,1,2,3; each source's data written exactly twice in that order.
- Only source 2 valid with data 5'h0A..5'h0F over 6 cycles -> six consecutive fifo_wr_req_o with data 0A..0F; req_ready_o=4'b0100 every cycle.
- fifo_full_i=1 for 3 cycles with all valid -> fifo_wr_req_o=0 and req_ready_o=0 throughout; after full drops, the first grant equals the pre-stall rr_ptr.
- Valid=4'b1010 with rr_ptr=0 -> grant 1, then 3, then 1. Drop source 3 valid mid-sequence -> source 1 granted every cycle.
- FIFO_ARB_BURST_EN, BURST_MAX=4, all valid -> grants 0,0,0,0,1,1,1,1,... With source 0 dropping valid after 2 beats -> 0,0,(idle),1,1,1,1.
- Assert a_rst_n_i low asynchronously mid-burst (LOCK, burst_cnt=2) -> after release, grant restarts at source 0 with a full-length burst; no write while full at any time (assertion).
